// File: rtl/stage1_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests, buffers responses
// in order and drives the IF/ID register. Define FETCH_PERF_CNT_EN to add performance counters.
module stage1_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] idata,
    output logic [31:0] pc_ID,
    output logic        valid_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);
    localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]       NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    logic [PTR_W-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [31:0]      idata_q, idata_d;
    logic [31:0]      pc_id_q, pc_id_d;
    logic             valid_q, valid_d;

    logic [31:0] tag_mem      [FIFO_DEPTH];
    logic [31:0] buf_data_mem [FIFO_DEPTH];
    logic [31:0] buf_pc_mem   [FIFO_DEPTH];

    logic           buf_empty, can_pop, pop, req_fire, resp_keep;
    logic [CNT_W:0] credit_used;

    assign imem_addr = pc_q;
    assign idata     = idata_q;
    assign pc_ID     = pc_id_q;
    assign valid_ID  = valid_q;

    // Credit counts a head entry leaving this cycle as free, so a 1-cycle memory sustains 1 word/cycle.
    always_comb begin
        buf_empty   = (buf_cnt_q == '0);
        can_pop     = stall && !buf_empty;
        credit_used = {1'b0, out_q} + {1'b0, buf_cnt_q} - (CNT_W + 1)'(can_pop);
        imem_req    = (state_q == ST_RUN) && (credit_used < DEPTH_C);
        req_fire    = imem_req && imem_gnt;
        resp_keep   = imem_rvalid && (kill_q == '0) && !redirect;
        pop         = can_pop && !redirect;
    end

    always_comb begin
        out_d = out_q + CNT_W'(req_fire) - CNT_W'(imem_rvalid);
        pc_d  = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        // Requests already granted (including this cycle's) become wrong-path on redirect.
        kill_d = kill_q;
        if (redirect) begin
            kill_d = out_d;
        end else if (imem_rvalid && (kill_q != '0)) begin
            kill_d = kill_q - CNT_W'(1);
        end

        tag_wr_d  = '0;
        tag_rd_d  = '0;
        buf_wr_d  = '0;
        buf_rd_d  = '0;
        buf_cnt_d = '0;
        if (!redirect) begin
            tag_wr_d  = tag_wr_q + PTR_W'(req_fire);
            tag_rd_d  = tag_rd_q + PTR_W'(resp_keep);
            buf_wr_d  = buf_wr_q + PTR_W'(resp_keep);
            buf_rd_d  = buf_rd_q + PTR_W'(pop);
            buf_cnt_d = buf_cnt_q + CNT_W'(resp_keep) - CNT_W'(pop);
        end

        idata_d = idata_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        if (redirect) begin
            idata_d = NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            if (buf_empty) begin
                idata_d = NOP;
                valid_d = 1'b0;
            end else begin
                idata_d = buf_data_mem[buf_rd_q];
                pc_id_d = buf_pc_mem[buf_rd_q];
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_FLUSH: if (kill_d == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
        if (redirect) begin
            state_d = (kill_d != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            kill_q    <= '0;
            buf_cnt_q <= '0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            idata_q   <= NOP;
            pc_id_q   <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_q     <= out_d;
            kill_q    <= kill_d;
            buf_cnt_q <= buf_cnt_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            idata_q   <= idata_d;
            pc_id_q   <= pc_id_d;
            valid_q   <= valid_d;
        end
    end

    // Storage carries no reset: pointers and counts alone define which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire && !redirect) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (resp_keep) begin
            buf_data_mem[buf_wr_q] <= imem_rdata;
            buf_pc_mem[buf_wr_q]   <= tag_mem[tag_rd_q];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, kill_cnt_q, bubble_cnt_q;
    logic        resp_drop;

    assign resp_drop       = imem_rvalid && !resp_keep;
    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_kill_cnt   = kill_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            kill_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + 32'(req_fire);
            kill_cnt_q   <= kill_cnt_q + 32'(resp_drop);
            bubble_cnt_q <= bubble_cnt_q + 32'(can_pop == 1'b0 && stall);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> (out_q != '0));

endmodule

// File: tb/tb_stage1_fetch.sv
// Bench for stage1_fetch: directed vector table for the fetch/stall/redirect/grant corners,
// then randomized traffic checked cycle by cycle against a queue-level model of the fetch stage.
`timescale 1ns/1ps
module tb_stage1_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          NV       = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_ID;
    logic [31:0] imem_addr, idata, pc_ID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_kill_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    stage1_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .idata(idata), .pc_ID(pc_ID), .valid_ID(valid_ID)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit s; bit r; logic [31:0] rpc; bit g; int lat;
        bit e_req; logic [31:0] e_addr; bit e_v; logic [31:0] e_d; logic [31:0] e_pc;
    } vec_t;

    mreq_t       mem_q[$];
    logic [31:0] mem_key;
    int          cyc;
    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model: in-flight live tags, count of doomed responses, buffered PCs, IF/ID.
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_tags[$];
    int          m_kill;
    logic [31:0] m_buf[$];
    bit          m_valid;
    logic [31:0] m_idata, m_pcid;
    logic [31:0] m_fetch, m_drop, m_bubble;

    vec_t tbl[NV];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ mem_key;
    endfunction

    function automatic vec_t mk(input bit s, input bit r, input logic [31:0] rpc, input bit g,
                                input int lat, input bit e_req, input logic [31:0] e_addr,
                                input bit e_v, input logic [31:0] e_d, input logic [31:0] e_pc);
        vec_t v;
        v.s = s; v.r = r; v.rpc = rpc; v.g = g; v.lat = lat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_d = e_d; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_pc = RESET_PC; m_tags.delete(); m_kill = 0; m_buf.delete();
        m_valid = 1'b0; m_idata = NOP; m_pcid = 32'h0;
        m_fetch = '0; m_drop = '0; m_bubble = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, ".addr"}, imem_addr, RESET_PC);
        chk({tag, ".idata"}, idata, NOP);
        chk({tag, ".pc_ID"}, pc_ID, 32'h0);
        chk({tag, ".valid"}, {31'd0, valid_ID}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".perf_fetch"}, perf_fetch_cnt, 32'h0);
        chk({tag, ".perf_kill"}, perf_kill_cnt, 32'h0);
        chk({tag, ".perf_bubble"}, perf_bubble_cnt, 32'h0);
`endif
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".perf_fetch"}, perf_fetch_cnt, m_fetch);
        chk({tag, ".perf_kill"}, perf_kill_cnt, m_drop);
        chk({tag, ".perf_bubble"}, perf_bubble_cnt, m_bubble);
`else
        if (tag.len() == 0) $display("(no perf counters)");
`endif
    endtask

    // One clock cycle: drive inputs, check combinational request side, clock, check IF/ID.
    task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit g, input int lat,
                        output bit o_req, output logic [31:0] o_addr);
        bit pop, mreq, fire, rv;
        int outst;
        stall = s; redirect = r; redirect_pc = rpc; imem_gnt = g;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_data(mem_q[0].addr) : 32'h0;
        #1;
        o_req  = imem_req;
        o_addr = imem_addr;
        pop   = s && (m_buf.size() > 0);
        outst = m_tags.size() + m_kill;
        mreq  = !m_boot && (m_kill == 0) && (outst + m_buf.size() - int'(pop) < DEPTH);
        chk("model.req", {31'd0, imem_req}, {31'd0, mreq});
        chk("model.addr", imem_addr, m_pc);
        fire = mreq && g;

        if (rv) void'(mem_q.pop_front());
        if (imem_req && g) mem_q.push_back('{addr: imem_addr, due: cyc + lat});

        if (s && m_buf.size() == 0) m_bubble++;
        if (fire) m_fetch++;
        if (r) begin
            if (rv) m_drop++;
            m_kill = m_tags.size() + m_kill + int'(fire) - int'(rv);
            m_tags.delete();
            m_buf.delete();
            m_pc = rpc; m_valid = 1'b0; m_idata = NOP; m_boot = 1'b0;
        end else begin
            if (s) begin
                if (m_buf.size() > 0) begin
                    m_pcid = m_buf.pop_front(); m_idata = mem_data(m_pcid); m_valid = 1'b1;
                end else begin
                    m_idata = NOP; m_valid = 1'b0;
                end
            end
            if (rv) begin
                if (m_kill > 0) begin
                    m_kill--; m_drop++;
                end else if (m_tags.size() > 0) begin
                    m_buf.push_back(m_tags.pop_front());
                end
            end
            if (fire) begin
                m_tags.push_back(m_pc); m_pc = m_pc + 32'd4;
            end
            m_boot = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("model.valid", {31'd0, valid_ID}, {31'd0, m_valid});
        chk("model.idata", idata, m_idata);
        if (m_valid) chk("model.pc_ID", pc_ID, m_pcid);
    endtask

    // Asynchronous reset asserted mid-cycle with traffic in flight.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        mem_q.delete();
        imem_rvalid = 1'b0; imem_gnt = 1'b0; stall = 1'b0; redirect = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_hold"});
        rst_n = 1'b1;
        $display("reset %s: asserted mid-transaction, outputs checked", tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          o_req, rs, rr, rg;
        logic [31:0] o_addr, rt;
        int          rl;

        tbl[0]  = mk(1, 0, 0,          1, 1, 0, 32'h000, 0, NOP,     0);
        tbl[1]  = mk(1, 0, 0,          1, 1, 1, 32'h000, 0, NOP,     0);
        tbl[2]  = mk(1, 0, 0,          1, 1, 1, 32'h004, 0, NOP,     0);
        tbl[3]  = mk(1, 0, 0,          1, 1, 1, 32'h008, 1, 32'h000, 32'h000);
        tbl[4]  = mk(1, 0, 0,          1, 1, 1, 32'h00C, 1, 32'h004, 32'h004);
        tbl[5]  = mk(1, 0, 0,          1, 1, 1, 32'h010, 1, 32'h008, 32'h008);
        tbl[6]  = mk(0, 0, 0,          1, 1, 0, 32'h014, 1, 32'h008, 32'h008);
        tbl[7]  = mk(0, 0, 0,          1, 1, 0, 32'h014, 1, 32'h008, 32'h008);
        tbl[8]  = mk(0, 0, 0,          1, 1, 0, 32'h014, 1, 32'h008, 32'h008);
        tbl[9]  = mk(0, 0, 0,          1, 1, 0, 32'h014, 1, 32'h008, 32'h008);
        tbl[10] = mk(1, 0, 0,          1, 1, 1, 32'h014, 1, 32'h00C, 32'h00C);
        tbl[11] = mk(1, 0, 0,          1, 1, 1, 32'h018, 1, 32'h010, 32'h010);
        tbl[12] = mk(1, 0, 0,          1, 3, 1, 32'h01C, 1, 32'h014, 32'h014);
        tbl[13] = mk(1, 0, 0,          1, 3, 1, 32'h020, 1, 32'h018, 32'h018);
        tbl[14] = mk(1, 1, 32'h100,    0, 1, 0, 32'h024, 0, NOP,     0);
        tbl[15] = mk(1, 0, 0,          1, 1, 0, 32'h100, 0, NOP,     0);
        tbl[16] = mk(1, 0, 0,          1, 1, 0, 32'h100, 0, NOP,     0);
        tbl[17] = mk(1, 0, 0,          1, 1, 1, 32'h100, 0, NOP,     0);
        tbl[18] = mk(1, 0, 0,          1, 1, 1, 32'h104, 0, NOP,     0);
        tbl[19] = mk(1, 0, 0,          1, 1, 1, 32'h108, 1, 32'h100, 32'h100);
        tbl[20] = mk(1, 1, 32'h200,    1, 1, 1, 32'h10C, 0, NOP,     0);
        tbl[21] = mk(1, 0, 0,          1, 1, 0, 32'h200, 0, NOP,     0);
        tbl[22] = mk(1, 0, 0,          1, 1, 1, 32'h200, 0, NOP,     0);
        tbl[23] = mk(1, 0, 0,          1, 1, 1, 32'h204, 0, NOP,     0);
        tbl[24] = mk(1, 0, 0,          1, 1, 1, 32'h208, 1, 32'h200, 32'h200);
        tbl[25] = mk(1, 0, 0,          0, 1, 1, 32'h20C, 1, 32'h204, 32'h204);
        tbl[26] = mk(1, 0, 0,          0, 1, 1, 32'h20C, 1, 32'h208, 32'h208);
        tbl[27] = mk(1, 0, 0,          0, 1, 1, 32'h20C, 0, NOP,     0);
        tbl[28] = mk(1, 0, 0,          0, 1, 1, 32'h20C, 0, NOP,     0);
        tbl[29] = mk(1, 0, 0,          0, 1, 1, 32'h20C, 0, NOP,     0);
        tbl[30] = mk(1, 0, 0,          1, 1, 1, 32'h20C, 0, NOP,     0);
        tbl[31] = mk(1, 0, 0,          1, 1, 1, 32'h210, 0, NOP,     0);
        tbl[32] = mk(1, 0, 0,          1, 1, 1, 32'h214, 1, 32'h20C, 32'h20C);

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mem_key = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc = 0;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].rpc, tbl[i].g, tbl[i].lat, o_req, o_addr);
            chk($sformatf("vec%0d.req", i), {31'd0, o_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d.addr", i), o_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.valid", i), {31'd0, valid_ID}, {31'd0, tbl[i].e_v});
            chk($sformatf("vec%0d.idata", i), idata, tbl[i].e_d);
            if (tbl[i].e_v) chk($sformatf("vec%0d.pc_ID", i), pc_ID, tbl[i].e_pc);
            $display("vec %0d: stall=%0d redir=%0d gnt=%0d req=%0d addr=%h -> valid=%0d idata=%h pc_ID=%h",
                     i, tbl[i].s, tbl[i].r, tbl[i].g, o_req, o_addr, valid_ID, idata, pc_ID);
        end
        check_perf("table");

        mid_reset("midreset0");
        mem_key = 32'h1234_5678;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 29) == 0);
            rt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                              : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rg = ($urandom_range(0, 3) != 0);
            rl = $urandom_range(1, 3);
            if (i == 1500) begin
                check_perf("random_a");
                mid_reset("midreset1");
            end
            step(rs, rr, rt, rg, rl, o_req, o_addr);
        end
        check_perf("random_b");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
